psa_accum_seq: RTL and testbench

- Sequencer that uses one 4-lane partitioned saturating adder, the PADDSB datapath, to reduce a stream of 16-bit operand words into one lane-wise saturating sum.
- Each lane is a 4-bit two's-complement value. Overflow clamps that lane only.
- Sits between the execute stage and the PADDSB unit for multi-word vector-accumulate operations.
- Operands arrive over a valid/ready stream. The result, per-lane sticky saturation flags and a done pulse are returned.

---
 rtl/psa_accum_seq.sv | 114 +++++++++++
 tb/tb_psa_accum_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/psa_accum_seq.sv
// psa_accum_seq
// Reduces a stream of 16-bit operand words into one lane-wise saturating sum.
// The datapath is a 4-lane partitioned saturating adder (PADDSB style), and
// each lane holds a 4-bit two's-complement value.
// Each lane keeps a sticky flag that records any saturation since the last start.
// A three-state sequencer (IDLE -> ACC -> DONE) controls the beat handshakes
// and produces a one-cycle done pulse once the last beat has been added.

module psa_accum_seq #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic [3:0]       lane_sat,
    output logic             err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [15:0]      acc;
    logic [LEN_W-1:0] remaining;
    logic [3:0]       sat_flags;

    logic [15:0]      psa_sum;
    logic [3:0]       psa_ovf;
    logic [3:0]       a_l;
    logic [3:0]       b_l;
    logic [3:0]       s_l;
    logic             handshake;

    assign in_ready  = (state == ST_ACC);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign result    = acc;
    assign lane_sat  = sat_flags;
    assign err       = |sat_flags;
    assign handshake = in_valid & in_ready;

    // Partitioned saturating add of acc and in_data; carries never cross lanes
    always_comb begin
        psa_sum = '0;
        psa_ovf = '0;
        a_l     = '0;
        b_l     = '0;
        s_l     = '0;
        for (int i = 0; i < 4; i++) begin
            a_l = acc[i*4 +: 4];
            b_l = in_data[i*4 +: 4];
            s_l = a_l + b_l;
            psa_ovf[i] = (a_l[3] == b_l[3]) && (s_l[3] != a_l[3]);
            if (psa_ovf[i]) begin
                psa_sum[i*4 +: 4] = a_l[3] ? 4'b1000 : 4'b0111;
            end else begin
                psa_sum[i*4 +: 4] = s_l;
            end
        end
    end

    // Sequencer plus accumulator, flag and beat-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            remaining <= '0;
            sat_flags <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        sat_flags <= '0;
                        if (len != '0) begin
                            remaining <= len;
                            state     <= ST_ACC;
                        end else begin
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_ACC: begin
                    if (clr) begin
                        state <= ST_IDLE;
                    end else if (handshake) begin
                        acc       <= psa_sum;
                        sat_flags <= sat_flags | psa_ovf;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psa_accum_seq.sv
// tb_psa_accum_seq
// Scoreboard bench for psa_accum_seq. Each operation pushes the expected
// result and flags, which come from a clamp-based integer lane model. A
// negedge monitor pops that entry whenever done is seen and compares it.

module tb_psa_accum_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  lane_sat;
    logic        err;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  sat;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] beat_q[$];
    int          check_cnt = 0;
    int          pass_cnt  = 0;
    int          done_cnt  = 0;
    int          start_cnt = 0;
    int          ready_cnt = 0;

    psa_accum_seq #(.LEN_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .lane_sat (lane_sat),
        .err      (err)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it does not match
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        check_cnt++;
        if (obs !== expv) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference lane model: add as signed integers and clamp to [-8, 7]
    function automatic logic [19:0] model_psa(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  o;
        int          s;
        r = '0;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            s = int'($signed(a[i*4 +: 4])) + int'($signed(b[i*4 +: 4]));
            if (s > 7) begin
                s = 7;
                o[i] = 1'b1;
            end else if (s < -8) begin
                s = -8;
                o[i] = 1'b1;
            end
            r[i*4 +: 4] = s[3:0];
        end
        return {o, r};
    endfunction

    // Scoreboard consumer plus counters for done pulses and ready cycles
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_ready) ready_cnt++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("result", {16'd0, result}, {16'd0, e.res});
                    checkOutput("lane_sat", {28'd0, lane_sat}, {28'd0, e.sat});
                    checkOutput("err", {31'd0, err}, {31'd0, |e.sat});
                end
            end
        end
    end

    // Run one reduction using beat_q; vmask selects the cycles where in_valid is high
    task automatic applyStimulus(input logic [3:0] len_v, input int ncyc,
                                 input logic [15:0] vmask, input bit hold_start);
        exp_t        e;
        logic [19:0] r;
        int          bi;
        e.res = '0;
        e.sat = '0;
        for (int k = 0; k < int'(len_v); k++) begin
            r = model_psa(e.res, beat_q[k]);
            e.res = r[15:0];
            e.sat = e.sat | r[19:16];
        end
        exp_q.push_back(e);
        start_cnt++;
        ready_cnt = 0;
        start = 1'b1;
        len   = len_v;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        len = 4'd1;
        bi  = 0;
        for (int c = 0; c < ncyc; c++) begin
            in_valid = vmask[c];
            in_data  = vmask[c] ? beat_q[bi] : 16'hDEAD;
            @(posedge clk); #1;
            if (vmask[c]) bi++;
        end
        in_valid = 1'b0;
        checkOutput("done_latency", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("ready_cycles", ready_cnt, ncyc);
        checkOutput("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; clr = 1'b0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {in_ready, busy, done, err, lane_sat, result}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sum
        beat_q = '{16'h1234, 16'h1111};
        applyStimulus(4'd2, 2, 16'h0003, 1'b0);
        // Positive saturation then recovery
        beat_q = '{16'h0007, 16'h0001, 16'hFFFF};
        applyStimulus(4'd3, 3, 16'h0007, 1'b0);
        // Negative saturation
        beat_q = '{16'h8000, 16'h8000};
        applyStimulus(4'd2, 2, 16'h0003, 1'b0);
        beat_q = '{16'h0808, 16'h0808};
        applyStimulus(4'd2, 2, 16'h0003, 1'b0);
        // Stall pattern 1,0,0,1,0,1
        beat_q = '{16'h0001, 16'h0001, 16'h0001};
        applyStimulus(4'd3, 6, 16'h0029, 1'b0);
        // Zero length
        beat_q = {};
        applyStimulus(4'd0, 0, 16'h0000, 1'b0);
        // start held through ACC and DONE must be ignored
        beat_q = '{16'h1111, 16'h2222, 16'h3333};
        applyStimulus(4'd3, 3, 16'h0007, 1'b1);
        // Max length with mixed signs
        beat_q = {};
        for (int k = 0; k < 15; k++) beat_q.push_back(16'(k * 16'h1357 + 16'h0F21));
        applyStimulus(4'd15, 15, 16'h7FFF, 1'b0);

        // Abort after one of four beats; clr beats a simultaneous handshake
        start = 1'b1; len = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111;
        @(posedge clk); #1;
        clr = 1'b1; in_data = 16'h4444;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        checkOutput("clr_idle", {30'd0, busy, done}, 32'd0);
        checkOutput("clr_keeps_acc", {16'd0, result}, 32'h1111);
        @(posedge clk); #1;
        beat_q = '{16'h2222};
        applyStimulus(4'd1, 1, 16'h0001, 1'b0);

        // Asynchronous reset in mid-ACC with saturation already flagged
        start = 1'b1; len = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h7777;
        @(posedge clk); #1;
        in_data = 16'h1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("presat_flags", {28'd0, lane_sat}, 32'hF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {in_ready, busy, done, err, lane_sat, result}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat_q = '{16'h1000};
        applyStimulus(4'd1, 1, 16'h0001, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_count", done_cnt, start_cnt);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
